// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 INCR-burst subordinate memory model with programmable read latency
module axi_mem_responder #(
    parameter int DataWidth   = 64,
    parameter int AddrWidth   = 64,
    parameter int IdWidth     = 4,
    parameter int MemWords    = 4096,
    parameter int ReadLatency = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   aw_valid_i,
    output logic                   aw_ready_o,
    input  logic [IdWidth-1:0]     aw_id_i,
    input  logic [AddrWidth-1:0]   aw_addr_i,
    input  logic [7:0]             aw_len_i,
    input  logic                   w_valid_i,
    output logic                   w_ready_o,
    input  logic [DataWidth-1:0]   w_data_i,
    input  logic [DataWidth/8-1:0] w_strb_i,
    input  logic                   w_last_i,
    output logic                   b_valid_o,
    input  logic                   b_ready_i,
    output logic [IdWidth-1:0]     b_id_o,
    output logic [1:0]             b_resp_o,
    input  logic                   ar_valid_i,
    output logic                   ar_ready_o,
    input  logic [IdWidth-1:0]     ar_id_i,
    input  logic [AddrWidth-1:0]   ar_addr_i,
    input  logic [7:0]             ar_len_i,
    output logic                   r_valid_o,
    input  logic                   r_ready_i,
    output logic [IdWidth-1:0]     r_id_o,
    output logic [DataWidth-1:0]   r_data_o,
    output logic [1:0]             r_resp_o,
    output logic                   r_last_o
);
    localparam int StrbWidth = DataWidth / 8;
    localparam int OffBits   = $clog2(StrbWidth);
    localparam int IdxBits   = $clog2(MemWords);
    localparam logic [AddrWidth-1:0] Depth = AddrWidth'(MemWords);
    localparam logic [7:0] LatInit = 8'(ReadLatency);

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    logic [DataWidth-1:0] mem_q [MemWords];

    logic [1:0]           wstate_q, wstate_d;
    logic [IdWidth-1:0]   wid_q, wid_d;
    logic [AddrWidth-1:0] widx_q, widx_d;
    logic [7:0]           wlen_q, wlen_d;
    logic [7:0]           wbeat_q, wbeat_d;
    logic [1:0]           werr_q, werr_d;

    logic [1:0]           rstate_q, rstate_d;
    logic [IdWidth-1:0]   rid_q, rid_d;
    logic [AddrWidth-1:0] ridx_q, ridx_d;
    logic [7:0]           rlen_q, rlen_d;
    logic [7:0]           rbeat_q, rbeat_d;
    logic [7:0]           rlat_q, rlat_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic [1:0]           rresp_q, rresp_d;

    logic                 aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                 w_last_beat, w_oob, r_oob, r_last, rd_load;
    logic [AddrWidth-1:0] aw_idx, ar_idx, rd_idx;

    assign aw_ready_o = wstate_q == W_IDLE;
    assign w_ready_o  = wstate_q == W_DATA;
    assign b_valid_o  = wstate_q == W_RESP;
    assign b_id_o     = wid_q;
    assign b_resp_o   = werr_q;

    assign ar_ready_o = rstate_q == R_IDLE;
    assign r_valid_o  = rstate_q == R_DATA;
    assign r_id_o     = rid_q;
    assign r_data_o   = rdata_q;
    assign r_resp_o   = rresp_q;
    assign r_last     = rbeat_q == rlen_q;
    assign r_last_o   = r_valid_o & r_last;

    assign aw_hs = aw_valid_i & aw_ready_o;
    assign w_hs  = w_valid_i & w_ready_o;
    assign b_hs  = b_valid_o & b_ready_i;
    assign ar_hs = ar_valid_i & ar_ready_o;
    assign r_hs  = r_valid_o & r_ready_i;

    // Full-width word index: any nonzero bit above the array range lands out of range
    assign aw_idx      = aw_addr_i >> OffBits;
    assign ar_idx      = ar_addr_i >> OffBits;
    assign w_oob       = widx_q >= Depth;
    assign w_last_beat = wbeat_q == wlen_q;

    // Write FSM next state; DECERR is sticky and outranks SLVERR
    always_comb begin
        wstate_d = wstate_q;
        wid_d    = wid_q;
        widx_d   = widx_q;
        wlen_d   = wlen_q;
        wbeat_d  = wbeat_q;
        werr_d   = werr_q;
        if (aw_hs) begin
            wstate_d = W_DATA;
            wid_d    = aw_id_i;
            widx_d   = aw_idx;
            wlen_d   = aw_len_i;
            wbeat_d  = 8'd0;
            werr_d   = RespOkay;
        end
        if (w_hs) begin
            werr_d   = w_oob ? RespDecErr :
                       (w_last_i != w_last_beat && werr_q != RespDecErr) ? RespSlvErr : werr_q;
            wstate_d = w_last_beat ? W_RESP : W_DATA;
            widx_d   = widx_q + 1'b1;
            wbeat_d  = wbeat_q + 8'd1;
        end
        if (b_hs) begin
            wstate_d = W_IDLE;
            werr_d   = RespOkay;
        end
    end

    // Read FSM next state; rd_load samples the array for the beat about to be presented
    always_comb begin
        rstate_d = rstate_q;
        rid_d    = rid_q;
        ridx_d   = ridx_q;
        rlen_d   = rlen_q;
        rbeat_d  = rbeat_q;
        rlat_d   = rlat_q;
        rd_load  = 1'b0;
        rd_idx   = ridx_q;
        if (ar_hs) begin
            rstate_d = (ReadLatency == 0) ? R_DATA : R_WAIT;
            rid_d    = ar_id_i;
            ridx_d   = ar_idx;
            rlen_d   = ar_len_i;
            rbeat_d  = 8'd0;
            rlat_d   = LatInit;
            rd_load  = ReadLatency == 0;
            rd_idx   = ar_idx;
        end
        if (rstate_q == R_WAIT) begin
            rlat_d   = rlat_q - 8'd1;
            rstate_d = (rlat_q == 8'd0) ? R_DATA : R_WAIT;
            rd_load  = rlat_q == 8'd0;
        end
        if (r_hs) begin
            rstate_d = r_last ? R_IDLE : R_DATA;
            rd_load  = !r_last;
            rd_idx   = ridx_q + 1'b1;
            ridx_d   = r_last ? ridx_q : rd_idx;
            rbeat_d  = r_last ? rbeat_q : rbeat_q + 8'd1;
        end
        r_oob   = rd_idx >= Depth;
        rdata_d = rd_load ? (r_oob ? '0 : mem_q[rd_idx[IdxBits-1:0]]) : rdata_q;
        rresp_d = rd_load ? (r_oob ? RespDecErr : RespOkay) : rresp_q;
    end

    // Array write with byte strobes; contents survive reset
    always_ff @(posedge clk_i) begin
        if (w_hs && !w_oob)
            for (int b = 0; b < StrbWidth; b++)
                if (w_strb_i[b])
                    mem_q[widx_q[IdxBits-1:0]][8*b +: 8] <= w_data_i[8*b +: 8];
    end

    // Write channel registers; reset drops any in-flight burst
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wstate_q <= W_IDLE;
            wid_q    <= '0;
            widx_q   <= '0;
            wlen_q   <= '0;
            wbeat_q  <= '0;
            werr_q   <= RespOkay;
        end else begin
            wstate_q <= wstate_d;
            wid_q    <= wid_d;
            widx_q   <= widx_d;
            wlen_q   <= wlen_d;
            wbeat_q  <= wbeat_d;
            werr_q   <= werr_d;
        end
    end

    // Read channel registers; reset drops any in-flight burst
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rstate_q <= R_IDLE;
            rid_q    <= '0;
            ridx_q   <= '0;
            rlen_q   <= '0;
            rbeat_q  <= '0;
            rlat_q   <= '0;
            rdata_q  <= '0;
            rresp_q  <= RespOkay;
        end else begin
            rstate_q <= rstate_d;
            rid_q    <= rid_d;
            ridx_q   <= ridx_d;
            rlen_q   <= rlen_d;
            rbeat_q  <= rbeat_d;
            rlat_q   <= rlat_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder: directed bursts with a queue scoreboard checked by a decoupled monitor
module tb_axi_mem_responder;
    localparam int DW = 64;
    localparam int AW = 64;
    localparam int IW = 4;
    localparam int MW = 4096;
    localparam int RL = 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          aw_valid_i, aw_ready_o;
    logic [IW-1:0] aw_id_i;
    logic [AW-1:0] aw_addr_i;
    logic [7:0]    aw_len_i;
    logic          w_valid_i, w_ready_o;
    logic [DW-1:0] w_data_i;
    logic [7:0]    w_strb_i;
    logic          w_last_i;
    logic          b_valid_o, b_ready_i;
    logic [IW-1:0] b_id_o;
    logic [1:0]    b_resp_o;
    logic          ar_valid_i, ar_ready_o;
    logic [IW-1:0] ar_id_i;
    logic [AW-1:0] ar_addr_i;
    logic [7:0]    ar_len_i;
    logic          r_valid_o, r_ready_i;
    logic [IW-1:0] r_id_o;
    logic [DW-1:0] r_data_o;
    logic [1:0]    r_resp_o;
    logic          r_last_o;

    axi_mem_responder #(
        .DataWidth(DW), .AddrWidth(AW), .IdWidth(IW), .MemWords(MW), .ReadLatency(RL)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i),
        .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
        .w_strb_i(w_strb_i), .w_last_i(w_last_i),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i),
        .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
        .r_resp_o(r_resp_o), .r_last_o(r_last_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } r_exp_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [1:0]    resp;
    } b_exp_t;

    r_exp_t        rq[$];
    b_exp_t        bq[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] wd [8];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out", name);
    endtask

    // Pops one expectation per accepted B or R beat
    task automatic monitor();
        forever begin
            @(negedge clk_i);
            if (!rst_i && b_valid_o && b_ready_i) begin
                if (bq.size() == 0) timeout("b_unexpected");
                else begin
                    b_exp_t e;
                    e = bq.pop_front();
                    check("b_id", DW'(b_id_o), DW'(e.id));
                    check("b_resp", DW'(b_resp_o), DW'(e.resp));
                end
            end
            if (!rst_i && r_valid_o && r_ready_i) begin
                if (rq.size() == 0) timeout("r_unexpected");
                else begin
                    r_exp_t e;
                    e = rq.pop_front();
                    check("r_id", DW'(r_id_o), DW'(e.id));
                    check("r_data", r_data_o, e.data);
                    check("r_resp", DW'(r_resp_o), DW'(e.resp));
                    check("r_last", DW'(r_last_o), DW'(e.last));
                end
            end
        end
    endtask

    task automatic push_r(input logic [IW-1:0] id, input logic [DW-1:0] d, input logic [1:0] resp, input logic last);
        rq.push_back('{id, d, resp, last});
    endtask

    task automatic wr(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                      input int last_at, input int nbeats, input logic [7:0] strb,
                      input logic push, input logic [1:0] resp);
        int t;
        if (push) bq.push_back('{id, resp});
        aw_valid_i = 1'b1; aw_id_i = id; aw_addr_i = addr; aw_len_i = len;
        t = 0;
        @(negedge clk_i);
        while (!aw_ready_o && t < 50) begin @(negedge clk_i); t++; end
        if (!aw_ready_o) timeout("aw_ready");
        @(posedge clk_i); #1;
        aw_valid_i = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            w_valid_i = 1'b1; w_data_i = wd[i]; w_strb_i = strb; w_last_i = (i == last_at);
            t = 0;
            @(negedge clk_i);
            while (!w_ready_o && t < 50) begin @(negedge clk_i); t++; end
            if (!w_ready_o) timeout("w_ready");
            @(posedge clk_i); #1;
        end
        w_valid_i = 1'b0; w_last_i = 1'b0;
        if (push) begin
            @(negedge clk_i);
            check("b_valid_timing", DW'(b_valid_o), DW'(1));
            t = 0;
            while (bq.size() != 0 && t < 50) begin @(negedge clk_i); t++; end
            if (bq.size() != 0) timeout("b_drain");
            @(posedge clk_i); #1;
        end
    endtask

    task automatic rd(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len, input int exp_lat);
        int t;
        ar_valid_i = 1'b1; ar_id_i = id; ar_addr_i = addr; ar_len_i = len;
        t = 0;
        @(negedge clk_i);
        while (!ar_ready_o && t < 50) begin @(negedge clk_i); t++; end
        if (!ar_ready_o) timeout("ar_ready");
        @(posedge clk_i); #1;
        ar_valid_i = 1'b0;
        if (exp_lat >= 0) begin
            t = 0;
            @(negedge clk_i);
            while (!r_valid_o && t < 50) begin @(negedge clk_i); t++; end
            check("r_latency", DW'(t), DW'(exp_lat));
        end
    endtask

    task automatic drain_r();
        int t;
        t = 0;
        while (rq.size() != 0 && t < 200) begin @(posedge clk_i); t++; end
        if (rq.size() != 0) timeout("r_drain");
        @(posedge clk_i); #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_aw_ready"}, DW'(aw_ready_o), DW'(1));
        check({tag, "_ar_ready"}, DW'(ar_ready_o), DW'(1));
        check({tag, "_w_ready"}, DW'(w_ready_o), DW'(0));
        check({tag, "_b_valid"}, DW'(b_valid_o), DW'(0));
        check({tag, "_r_valid"}, DW'(r_valid_o), DW'(0));
    endtask

    initial begin
        int t;
        fork
            monitor();
        join_none
        rst_i = 1'b1;
        aw_valid_i = 1'b0; aw_id_i = '0; aw_addr_i = '0; aw_len_i = '0;
        w_valid_i = 1'b0; w_data_i = '0; w_strb_i = '0; w_last_i = 1'b0;
        ar_valid_i = 1'b0; ar_id_i = '0; ar_addr_i = '0; ar_len_i = '0;
        b_ready_i = 1'b1; r_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check_idle("reset");
        check("reset_r_last", DW'(r_last_o), DW'(0));
        check("reset_r_data", r_data_o, DW'(0));
        check("reset_b_resp", DW'(b_resp_o), DW'(0));
        @(posedge clk_i); #1;

        // Four-beat write then read back, with latency check
        wd[0] = 64'h11; wd[1] = 64'h22; wd[2] = 64'h33; wd[3] = 64'h44;
        wr(4'd3, 64'h40, 8'd3, 3, 4, 8'hFF, 1'b1, 2'b00);
        push_r(4'd5, 64'h11, 2'b00, 1'b0);
        push_r(4'd5, 64'h22, 2'b00, 1'b0);
        push_r(4'd5, 64'h33, 2'b00, 1'b0);
        push_r(4'd5, 64'h44, 2'b00, 1'b1);
        rd(4'd5, 64'h40, 8'd3, RL + 1);
        drain_r();

        // Partial strobes clear only the low half
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        wr(4'd4, 64'h0, 8'd0, 0, 1, 8'hFF, 1'b1, 2'b00);
        wd[0] = 64'h0;
        wr(4'd4, 64'h0, 8'd0, 0, 1, 8'h0F, 1'b1, 2'b00);
        push_r(4'd6, 64'hFFFF_FFFF_0000_0000, 2'b00, 1'b1);
        rd(4'd6, 64'h0, 8'd0, -1);
        drain_r();

        // Stall mid-burst: third beat must hold steady
        push_r(4'd5, 64'h11, 2'b00, 1'b0);
        push_r(4'd5, 64'h22, 2'b00, 1'b0);
        push_r(4'd5, 64'h33, 2'b00, 1'b0);
        push_r(4'd5, 64'h44, 2'b00, 1'b1);
        rd(4'd5, 64'h40, 8'd3, -1);
        t = 0;
        while (rq.size() > 2 && t < 50) begin @(posedge clk_i); t++; end
        #1 r_ready_i = 1'b0;
        repeat (5) begin
            @(negedge clk_i);
            check("stall_valid", DW'(r_valid_o), DW'(1));
            check("stall_data", r_data_o, 64'h33);
            check("stall_last", DW'(r_last_o), DW'(0));
            check("stall_id", DW'(r_id_o), DW'(5));
        end
        @(posedge clk_i); #1 r_ready_i = 1'b1;
        drain_r();

        // Burst running off the top of the array
        wd[0] = 64'hA5A5_0000_1234_5678; wd[1] = 64'h5A5A_5A5A_5A5A_5A5A;
        wr(4'd7, 64'((MW - 1) * 8), 8'd1, 1, 2, 8'hFF, 1'b1, 2'b11);
        push_r(4'd9, 64'hA5A5_0000_1234_5678, 2'b00, 1'b0);
        push_r(4'd9, 64'h0, 2'b11, 1'b1);
        rd(4'd9, 64'((MW - 1) * 8), 8'd1, -1);
        drain_r();

        // Early w_last: all beats still taken, SLVERR reported
        wd[0] = 64'h1; wd[1] = 64'h2; wd[2] = 64'h3;
        wr(4'd2, 64'h100, 8'd2, 1, 3, 8'hFF, 1'b1, 2'b10);
        push_r(4'd2, 64'h1, 2'b00, 1'b0);
        push_r(4'd2, 64'h2, 2'b00, 1'b0);
        push_r(4'd2, 64'h3, 2'b00, 1'b1);
        rd(4'd2, 64'h100, 8'd2, -1);
        drain_r();

        // Nonzero upper address bits are out of range, not aliased
        wd[0] = 64'hDEAD;
        wr(4'd1, 64'h1_0000_0040, 8'd0, 0, 1, 8'hFF, 1'b1, 2'b11);
        push_r(4'd1, 64'h0, 2'b11, 1'b1);
        rd(4'd1, 64'h1_0000_0040, 8'd0, -1);
        push_r(4'd1, 64'h11, 2'b00, 1'b1);
        rd(4'd1, 64'h40, 8'd0, -1);
        drain_r();

        // Reset mid-write and mid-read; memory retained
        wd[0] = 64'hAA; wd[1] = 64'hBB;
        wr(4'd8, 64'h200, 8'd3, 3, 2, 8'hFF, 1'b0, 2'b00);
        r_ready_i = 1'b0;
        rd(4'd8, 64'h40, 8'd3, -1);
        t = 0;
        @(negedge clk_i);
        while (!r_valid_o && t < 50) begin @(negedge clk_i); t++; end
        check("pre_reset_r_valid", DW'(r_valid_o), DW'(1));
        check("pre_reset_w_ready", DW'(w_ready_o), DW'(1));
        @(posedge clk_i); #1 rst_i = 1'b1;
        @(negedge clk_i);
        check("in_reset_r_valid", DW'(r_valid_o), DW'(0));
        check("in_reset_b_valid", DW'(b_valid_o), DW'(0));
        @(posedge clk_i); #1 rst_i = 1'b0; r_ready_i = 1'b1;
        @(negedge clk_i);
        check_idle("post_reset");
        repeat (3) @(negedge clk_i);
        check("post_reset_no_b", DW'(b_valid_o), DW'(0));
        @(posedge clk_i); #1;
        push_r(4'd3, 64'h11, 2'b00, 1'b0);
        push_r(4'd3, 64'h22, 2'b00, 1'b0);
        push_r(4'd3, 64'h33, 2'b00, 1'b0);
        push_r(4'd3, 64'h44, 2'b00, 1'b1);
        rd(4'd3, 64'h40, 8'd3, RL + 1);
        drain_r();
        push_r(4'd4, 64'hAA, 2'b00, 1'b0);
        push_r(4'd4, 64'hBB, 2'b00, 1'b1);
        rd(4'd4, 64'h200, 8'd1, -1);
        drain_r();

        repeat (3) @(posedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
